// File: rtl/mode_pkg.sv
// Shared encodings for the display-mode sequencer: mux select codes,
// FSM states, button indices and small state-mapping helpers.
package mode_pkg;

  // Codes presented to the 4:1 time mux.
  typedef enum logic [1:0] {
    MODE_12H = 2'b00,
    MODE_24H = 2'b01,
    MODE_SW  = 2'b10,
    MODE_TMR = 2'b11
  } mode_e;

  // Sequencer states; ALARM sits outside the select rotation.
  typedef enum logic [2:0] {
    ST_12H,
    ST_24H,
    ST_SW,
    ST_TMR,
    ST_ALARM
  } state_e;

  // Bit positions of the four buttons in the conditioned press vector.
  localparam int BTN_SELECT  = 0;
  localparam int BTN_TOGGLE  = 1;
  localparam int BTN_ADD_ONE = 2;
  localparam int BTN_ADD_TEN = 3;
  localparam int NUM_BTNS    = 4;

  // Mux code shown for a state; the alarm forces the timer view.
  function automatic mode_e state_to_mode(input state_e s);
    case (s)
      ST_12H:  return MODE_12H;
      ST_24H:  return MODE_24H;
      ST_SW:   return MODE_SW;
      default: return MODE_TMR;
    endcase
  endfunction

  // Select-button rotation 12H -> 24H -> SW -> TMR -> 12H.
  function automatic state_e next_mode_state(input state_e s);
    case (s)
      ST_12H:  return ST_24H;
      ST_24H:  return ST_SW;
      ST_SW:   return ST_TMR;
      default: return ST_12H;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button front end: 2-FF synchronizer, tick-sampled debounce,
// and a single-clk press pulse on the rising edge of the debounced level.
module btn_conditioner #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1khz,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] count;

  // Bring the asynchronous button level into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Accept a new level after DEBOUNCE_TICKS consecutive differing samples; pulse on acceptance of a 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      count <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick_1khz) begin
        if (sync_2 == level) begin
          count <= '0;
        end else if (count == CNT_LAST) begin
          level <= sync_2;
          count <= '0;
          press <= sync_2;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mode_controller.sv
// Display-mode sequencer: conditions the four buttons, rotates the mux
// select, routes toggle/add strobes to the owning block, runs the
// timer-expiry alarm with display blink, and registers the palette select.
module mode_controller
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int ALARM_TICKS    = 5000,
  parameter int BLINK_TICKS    = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1khz,
  input  logic       select_btn,
  input  logic       toggle_btn,
  input  logic       add_one_btn,
  input  logic       add_ten_btn,
  input  logic       timer_done,
  output logic [1:0] select,
  output logic       sw_toggle,
  output logic       tmr_toggle,
  output logic       tmr_add_one,
  output logic       tmr_add_ten,
  output logic       alarm_active,
  output logic       blank,
  output logic       palette
);

  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;
  logic                done_q;
  logic                done_rise;
  logic                any_press;
  logic                alarm_timeout;
  state_e              state;
  state_e              state_nxt;
  logic [AW-1:0]       alarm_cnt;
  logic [BW-1:0]       blink_cnt;

  assign btn_raw = {add_ten_btn, add_one_btn, toggle_btn, select_btn};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_btn (
      .clk      (clk),
      .reset    (reset),
      .tick_1khz(tick_1khz),
      .btn_raw  (btn_raw[i]),
      .press    (press[i])
    );
  end

  // Previous timer_done level, so expiry is taken only on its rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= timer_done;
  end

  assign done_rise     = timer_done & ~done_q;
  assign any_press     = |press;
  assign alarm_timeout = tick_1khz && (alarm_cnt == ALARM_LAST);

  // Next state: alarm entry beats any press; any press or timeout leaves the alarm.
  // NOTE: state_nxt is defaulted before any branch so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (state == ST_ALARM) begin
      if (any_press || alarm_timeout) state_nxt = ST_TMR;
    end else if (done_rise) begin
      state_nxt = ST_ALARM;
    end else if (press[BTN_SELECT]) begin
      state_nxt = next_mode_state(state);
    end
  end

  // Registered state, select/palette, routed strobes and alarm blink timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_12H;
      select       <= MODE_12H;
      palette      <= 1'b0;
      sw_toggle    <= 1'b0;
      tmr_toggle   <= 1'b0;
      tmr_add_one  <= 1'b0;
      tmr_add_ten  <= 1'b0;
      alarm_active <= 1'b0;
      blank        <= 1'b0;
      alarm_cnt    <= '0;
      blink_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      select       <= state_to_mode(state_nxt);
      palette      <= (state_nxt == ST_24H);
      alarm_active <= (state_nxt == ST_ALARM);
      // Strobes follow the mode the press arrived in; alarm entry swallows them.
      sw_toggle    <= press[BTN_TOGGLE]  && (state == ST_SW)  && !done_rise;
      tmr_toggle   <= press[BTN_TOGGLE]  && (state == ST_TMR) && !done_rise;
      tmr_add_one  <= press[BTN_ADD_ONE] && (state == ST_TMR) && !done_rise;
      tmr_add_ten  <= press[BTN_ADD_TEN] && (state == ST_TMR) && !done_rise;
      if ((state != ST_ALARM) || (state_nxt != ST_ALARM)) begin
        // Outside the alarm, and on entry/exit, timing restarts with the display lit.
        alarm_cnt <= '0;
        blink_cnt <= '0;
        blank     <= 1'b0;
      end else if (tick_1khz) begin
        alarm_cnt <= alarm_cnt + AW'(1);
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blank     <= ~blank;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: a behavioural model compared on
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_mode_controller;

  localparam int DEB          = 20;
  localparam int ALARM        = 5000;
  localparam int BLINK        = 250;
  localparam int CLK_PER_TICK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1khz = 1'b0;
  logic       timer_done = 1'b0;
  logic [3:0] btn = 4'b0000;   // 0 select, 1 toggle, 2 add_one, 3 add_ten
  logic [1:0] select;
  logic       sw_toggle, tmr_toggle, tmr_add_one, tmr_add_ten;
  logic       alarm_active, blank, palette;

  mode_controller #(
    .DEBOUNCE_TICKS(DEB),
    .ALARM_TICKS   (ALARM),
    .BLINK_TICKS   (BLINK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1khz   (tick_1khz),
    .select_btn  (btn[0]),
    .toggle_btn  (btn[1]),
    .add_one_btn (btn[2]),
    .add_ten_btn (btn[3]),
    .timer_done  (timer_done),
    .select      (select),
    .sw_toggle   (sw_toggle),
    .tmr_toggle  (tmr_toggle),
    .tmr_add_one (tmr_add_one),
    .tmr_add_ten (tmr_add_ten),
    .alarm_active(alarm_active),
    .blank       (blank),
    .palette     (palette)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- tick generation and observers ----------------
  int tick_div = 0;
  int tick_cnt = 0;
  int n_sw = 0, n_tt = 0, n_t1 = 0, n_t10 = 0;

  initial begin
    forever begin
      @(negedge clk);
      tick_1khz = (tick_div == CLK_PER_TICK - 1);
      tick_div  = (tick_div + 1) % CLK_PER_TICK;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (tick_1khz) tick_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_sw  += int'(sw_toggle);
      n_tt  += int'(tmr_toggle);
      n_t1  += int'(tmr_add_one);
      n_t10 += int'(tmr_add_ten);
    end
  end

  // ---------------- behavioural model ----------------
  // Buttons: each accepted level needs DEB consecutive differing ms samples of
  // the input as seen two clocks late. Mode: integer 0..3 rotating on select.
  // Alarm: counted in ms since entry; blank is the parity of elapsed/BLINK.
  logic [3:0] m_dly0 = '0, m_dly1 = '0;
  logic [3:0] m_lvl = '0, m_press = '0;
  int         m_run [4];
  int         m_mode = 0;
  bit         m_alarm = 0;
  int         m_t = 0;
  bit         m_done_prev = 0;
  bit         m_sw = 0, m_tt = 0, m_t1 = 0, m_t10 = 0;

  initial begin
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_dly0 = '0; m_dly1 = '0; m_lvl = '0; m_press = '0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_mode = 0; m_alarm = 0; m_t = 0; m_done_prev = 0;
        m_sw = 0; m_tt = 0; m_t1 = 0; m_t10 = 0;
      end else begin
        m_sw = 0; m_tt = 0; m_t1 = 0; m_t10 = 0;
        if (m_alarm) begin
          if (tick_1khz) m_t++;
          if (m_press != 0 || m_t == ALARM) begin
            m_alarm = 0;
            m_mode  = 3;
          end
        end else if (timer_done && !m_done_prev) begin
          m_alarm = 1;
          m_t     = 0;
        end else begin
          m_sw  = m_press[1] && (m_mode == 2);
          m_tt  = m_press[1] && (m_mode == 3);
          m_t1  = m_press[2] && (m_mode == 3);
          m_t10 = m_press[3] && (m_mode == 3);
          if (m_press[0]) m_mode = (m_mode + 1) % 4;
        end
        m_done_prev = timer_done;
        m_press = '0;
        if (tick_1khz) begin
          for (int b = 0; b < 4; b++) begin
            if (m_dly1[b] != m_lvl[b]) begin
              m_run[b]++;
              if (m_run[b] == DEB) begin
                m_lvl[b]   = m_dly1[b];
                m_run[b]   = 0;
                m_press[b] = m_lvl[b];
              end
            end else begin
              m_run[b] = 0;
            end
          end
        end
        m_dly1 = m_dly0;
        m_dly0 = btn;
      end
    end
  end

  function automatic logic [8:0] model_vec();
    logic [1:0] sel;
    logic       blank_e, pal_e;
    sel     = m_alarm ? 2'b11 : 2'(m_mode);
    blank_e = m_alarm && (((m_t / BLINK) % 2) == 1);
    pal_e   = !m_alarm && (m_mode == 1);
    return {sel, m_sw, m_tt, m_t1, m_t10, m_alarm, blank_e, pal_e};
  endfunction

  logic [8:0] dut_vec;
  assign dut_vec = {select, sw_toggle, tmr_toggle, tmr_add_one, tmr_add_ten,
                    alarm_active, blank, palette};

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) check("cycle", 32'(dut_vec), 32'(model_vec()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ms(input int n);
    repeat (n * CLK_PER_TICK) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold_ms);
    @(negedge clk);
    btn[b] = 1'b1;
    ms(hold_ms);
    btn[b] = 1'b0;
    ms(30);
  endtask

  int base;
  int n;
  logic prev_blank;

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(dut_vec), 32'h0);
    reset = 1'b0;

    // Mode rotation and palette
    press(0, 30); check("cycle_24h",  {select, palette}, 3'b011);
    press(0, 30); check("cycle_sw",   {select, palette}, 3'b100);
    press(0, 30); check("cycle_tmr",  {select, palette}, 3'b110);
    press(0, 30); check("cycle_12h",  {select, palette}, 3'b000);

    // Chatter every 5 ms for 40 ms, then stable high: one advance
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      btn[0] = ~btn[0];
      ms(5);
    end
    btn[0] = 1'b1; ms(30); btn[0] = 1'b0; ms(30);
    check("bounce_one_advance", select, 2'b01);
    // 15 ms pulse is too short
    @(negedge clk);
    btn[0] = 1'b1; ms(15); btn[0] = 1'b0; ms(30);
    check("short_pulse_ignored", select, 2'b01);

    // Routing
    press(0, 30); press(0, 30); press(0, 30);
    check("route_mode_12h", select, 2'b00);
    press(1, 30);
    check("toggle_12h_dropped", n_sw + n_tt, 0);
    press(0, 30); press(0, 30);
    press(1, 30);
    check("toggle_sw_pulse", n_sw, 1);
    press(2, 30);
    check("add_one_sw_dropped", n_t1, 0);
    press(0, 30);
    press(1, 30);
    check("toggle_tmr_pulse", n_tt, 1);
    press(3, 30);
    check("add_ten_tmr_pulse", n_t10, 1);
    press(2, 30);
    check("add_one_tmr_pulse", n_t1, 1);
    // Select + toggle together in TMR: toggle routed, then advance
    @(negedge clk);
    btn[0] = 1'b1; btn[1] = 1'b1; ms(30); btn = 4'b0000; ms(30);
    check("dual_press_toggle", n_tt, 2);
    check("dual_press_advance", select, 2'b00);
    check("dual_press_no_sw", n_sw, 1);

    // Alarm timeout from 24H
    press(0, 30);
    check("pre_alarm_24h", {select, palette}, 3'b011);
    @(negedge clk); timer_done = 1'b1;
    @(negedge clk);
    check("alarm_entry", {select, alarm_active, blank, palette}, 5'b11100);
    base = tick_cnt;
    prev_blank = blank;
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (blank == prev_blank && n < 2000) begin @(negedge clk); n++; end
      check($sformatf("blink_%0d", k), tick_cnt - base, BLINK * k);
      prev_blank = blank;
    end
    n = 0;
    while (alarm_active && n < 25000) begin @(negedge clk); n++; end
    check("alarm_timeout_ticks", tick_cnt - base, ALARM);
    check("alarm_timeout_out", {select, alarm_active, blank, palette}, 5'b11000);
    timer_done = 1'b0;

    // Alarm cancel by a toggle press ~1 s in
    ms(2); timer_done = 1'b1;
    @(negedge clk);
    check("alarm2_entry", alarm_active, 1'b1);
    ms(980);
    btn[1] = 1'b1;
    n = 0;
    while (alarm_active && n < 400) begin @(negedge clk); n++; end
    check("cancel_out", {select, alarm_active, blank}, 4'b1100);
    ms(30); btn[1] = 1'b0; ms(30);
    check("cancel_no_tmr_toggle", n_tt, 2);
    check("cancel_mode_tmr", select, 2'b11);
    timer_done = 1'b0;

    // Collision: timer_done edge in the same cycle the select press arrives
    ms(2);
    @(negedge clk); btn[0] = 1'b1;
    n = 0;
    while (!m_press[0] && n < 200) begin @(negedge clk); n++; end
    timer_done = 1'b1;
    @(negedge clk);
    check("collision_alarm", {select, alarm_active}, 3'b111);
    ms(30); btn[0] = 1'b0; ms(50);
    check("collision_alarm_holds", {select, alarm_active}, 3'b111);

    // Reset mid-alarm, with select held through reset release
    btn[0] = 1'b1; timer_done = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_mid_alarm", 32'(dut_vec), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ms(10);
    check("held_btn_not_yet", select, 2'b00);
    ms(20);
    check("held_btn_redebounced", {select, palette}, 3'b011);
    btn[0] = 1'b0; ms(30);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mode_controller.md
# mode_controller

Central sequencer for the clock/stopwatch/timer display system. Conditions the four raw push-buttons, owns the display-mode selection that drives the 4:1 time mux, and routes the toggle/add strobes to the sub-block that owns the current mode. It also runs the timer-expiry alarm (forced timer view plus display blink) and produces the registered VGA palette select.

## Interface
Parameters:
- DEBOUNCE_TICKS, 20: consecutive stable `tick_1khz` samples required to accept a button level (20 ms).
- ALARM_TICKS, 5000: alarm duration in `tick_1khz` ticks (5 s).
- BLINK_TICKS, 250: half-period of the alarm blink in ticks.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high; clears all state.
- tick_1khz  in  1  single-`clk` enable, once per ms.
- select_btn, toggle_btn, add_one_btn, add_ten_btn  in  1 each  raw, asynchronous button levels.
- timer_done  in  1  level from timer; high while the running timer has reached zero.
- select  out  2  mode to time mux: 00 = 12 h, 01 = 24 h, 10 = stopwatch, 11 = timer.
- sw_toggle  out  1  one-`clk` pulse to the stopwatch start/stop.
- tmr_toggle, tmr_add_one, tmr_add_ten  out  1 each  one-`clk` pulses to the timer.
- alarm_active  out  1  high during the alarm.
- blank  out  1  display blank request; toggles during the alarm.
- palette  out  1  0 = red pipeline, 1 = blue pipeline.

## Operation
- **Button conditioning**, per button:
  - 2-FF synchronizer.
  - Debounce counter sampled only on `tick_1khz`. The debounced level changes after DEBOUNCE_TICKS consecutive equal samples that differ from it; any mismatching sample resets the count.
  - Rising edge of the debounced level produces a one-`clk` press pulse.
- **Mode FSM**, states MODE_12H, MODE_24H, MODE_SW, MODE_TMR, ALARM.
  - A select press advances 12H→24H→SW→TMR→12H.
  - `select` is the registered state encoding. In ALARM, `select` = 11.
- **Routing** (presses outside these modes are dropped, never queued):
  - A toggle press in MODE_SW → `sw_toggle`.
  - A toggle press in MODE_TMR → `tmr_toggle`.
  - add_one/add_ten presses → `tmr_add_one`/`tmr_add_ten` only in MODE_TMR.
- **Alarm**:
  - A rising edge of `timer_done` (registered compare), in any non-ALARM state, enters ALARM.
  - On entry: the alarm tick counter and blink counter are cleared, `blank` = 0, and `alarm_active` = 1.
  - `blank` inverts every BLINK_TICKS ticks.
  - Exit to MODE_TMR when ALARM_TICKS ticks elapse or on any button press. The exiting press is consumed: no routed pulse and no mode advance.
  - On exit: `blank` = 0 and `alarm_active` = 0.
- **Palette**: `palette` = 1 iff the next-state `select` = 01. It is registered in the same cycle as `select`, so the two never disagree.

## Timing
- **Reset values**: `select` = 00, all pulses 0, `alarm_active` = 0, `blank` = 0, `palette` = 0. All debounced levels are 0 and all counters are 0.
- **Latency**:
  - From a clean raw edge to the press pulse: 2 clk (sync) + DEBOUNCE_TICKS ticks + ≤1 clk.
  - From the press pulse to `select`, `palette`, or the routed pulse: 1 clk, all registered.
- **Simultaneous events**:
  - A `timer_done` edge and any press in the same cycle: the alarm wins and the press is consumed.
  - Two different button presses in the same cycle: each is handled independently per the routing rules. A select press plus a toggle press routes the toggle per the old mode and then advances.
- **Counter saturation**:
  - Debounce counters saturate at DEBOUNCE_TICKS.
  - The alarm counter is sized by ALARM_TICKS via $clog2 and stops at its terminal value.
- **Reset mid-operation** (including mid-alarm or mid-debounce): immediate return to reset values and MODE_12H. A button held through reset release must re-debounce before it produces a press.
- Every routed output is high for exactly one `clk` per accepted press.

## Structure
- **Package mode_pkg**: mode encodings (MODE_12H = 2'b00, MODE_24H = 2'b01, MODE_SW = 2'b10, MODE_TMR = 2'b11) and the FSM state enum.
- **Sub-module btn_conditioner** (sync + debounce + edge detect, DEBOUNCE_TICKS parameter), instantiated four times.
- This block replaces the standalone select debouncer/counter and the top-level palette register.

## Test plan
- **Reset mode cycling**: after reset, four clean select presses (held 30 ms) → `select` 01, 10, 11, 00. `palette` = 1 only while `select` = 01, changing on the same edge.
- **Bounce rejection**: a select input chattering every 5 ms for 40 ms, then stable high → exactly one advance. A 15 ms pulse → no advance.
- **Routing**: toggle in mode 00 → no pulse. Toggle in mode 10 → single-cycle `sw_toggle`. Toggle/add_ten in mode 11 → single-cycle `tmr_toggle`/`tmr_add_ten`. add_one in mode 10 → no pulse.
- **Alarm timeout**: `timer_done` rises in mode 01 → `select` = 11 and `alarm_active` = 1 next clk. `blank` toggles at 250/500/750… ms. At 5000 ticks, `alarm_active` = 0, `blank` = 0, `select` = 11.
- **Alarm cancel**: a toggle press at 1 s into the alarm → alarm ends, no `tmr_toggle`, mode stays 11.
- **Collision and reset**: a `timer_done` edge in the same cycle as a select press → ALARM, no advance. Reset asserted mid-alarm → all outputs at reset values immediately.
